// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - state encoding, fun3 codes and byte-strobe patterns for the load/store unit
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_B    = 4'b0001;
  localparam logic [3:0] WSTRB_H    = 4'b0011;
  localparam logic [3:0] WSTRB_W    = 4'b1111;

  function automatic logic legal_load(input logic [2:0] f);
    return (f == LB) || (f == LH) || (f == LW) || (f == LBU) || (f == LHU);
  endfunction

  function automatic logic legal_store(input logic [2:0] f);
    return (f == SB) || (f == SH) || (f == SW);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - single-outstanding memory request/response bus between the LSU and memory
interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/strobes and load lane extraction/extension (combinational)
import lsu_pkg::*;

module lsu_align (
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_fun3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wstrb = WSTRB_W;
    st_wdata = st_data;
    case (st_size)
      2'b00: begin
        st_wstrb = WSTRB_B << st_lane;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_wstrb = WSTRB_H << {st_lane[1], 1'b0};
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_raw[7:0];
    case (ld_lane)
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      2'd3:    ld_byte = ld_raw[31:24];
      default: ld_byte = ld_raw[7:0];
    endcase
    ld_half = ld_lane[1] ? ld_raw[31:16] : ld_raw[15:0];

    case (ld_fun3)
      LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      LBU:     ld_data = {24'b0, ld_byte};
      LH:      ld_data = {{16{ld_half[15]}}, ld_half};
      LHU:     ld_data = {16'b0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - IDLE/REQ/WAIT/DONE load/store FSM with one outstanding memory access
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned half/word accesses instead of aligning them.
import lsu_pkg::*;

module load_store_unit (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             store,
  input  logic [2:0]       fun3,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             stall,
  output logic [31:0]      rdata,
  output logic             fault,
  lsu_mem_if.master        mem
);

  lsu_state_t  state;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [2:0]  ld_fun3_q;
  logic [1:0]  ld_lane_q;

  logic        access;
  logic        is_store;
  logic        legal;
  logic        misalign;
  logic        reject;
  logic [1:0]  size;
  logic [1:0]  eff_lane;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  // Load wins when the decoder asserts both strobes.
  assign access   = load | store;
  assign is_store = store & ~load;
  assign legal    = load ? legal_load(fun3) : legal_store(fun3);
  assign size     = fun3[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
  assign eff_lane = addr[1:0];
`else
  assign misalign = 1'b0;
  // Misaligned accesses silently drop the offending low bits.
  always_comb begin
    case (size)
      2'b00:   eff_lane = addr[1:0];
      2'b01:   eff_lane = {addr[1], 1'b0};
      default: eff_lane = 2'b00;
    endcase
  end
`endif

  assign reject = access & (~legal | misalign);

  lsu_align u_align (
    .st_size  (size),
    .st_lane  (eff_lane),
    .st_data  (wdata),
    .st_wstrb (st_wstrb),
    .st_wdata (st_wdata),
    .ld_fun3  (ld_fun3_q),
    .ld_lane  (ld_lane_q),
    .ld_raw   (mem.mem_rdata),
    .ld_data  (ld_data)
  );

  // The IDLE term is gated by rst_n so a decoder strobe held during reset cannot stall the core.
  assign stall = rst_n & (((state == S_IDLE) & access) | (state == S_REQ) | (state == S_WAIT));
  assign fault = rst_n & (state == S_IDLE) & reject;
  assign rdata = rdata_q;

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wstrb = wstrb_q;
  assign mem.mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'b0;
      wstrb_q   <= WSTRB_NONE;
      wdata_q   <= 32'b0;
      rdata_q   <= 32'b0;
      ld_fun3_q <= 3'b0;
      ld_lane_q <= 2'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            if (reject) begin
              rdata_q <= 32'b0;
              state   <= S_DONE;
            end else begin
              req_q     <= 1'b1;
              we_q      <= is_store;
              addr_q    <= {addr[31:2], 2'b00};
              wstrb_q   <= is_store ? st_wstrb : WSTRB_NONE;
              wdata_q   <= is_store ? st_wdata : 32'b0;
              ld_fun3_q <= fun3;
              ld_lane_q <= eff_lane;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_gnt) begin
            req_q <= 1'b0;
            state <= we_q ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_rvalid) begin
            rdata_q <= ld_data;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a randomized memory responder
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic        store;
  logic [2:0]  fun3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;

  lsu_mem_if mem ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .store (store),
    .fun3  (fun3),
    .addr  (addr),
    .wdata (wdata),
    .stall (stall),
    .rdata (rdata),
    .fault (fault),
    .mem   (mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fault;
    bit          has_req;
    bit          we;
    logic [31:0] maddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_rdata = 32'b0;

  int          gnt_delay = 0;
  int          rv_delay  = 0;
  logic [31:0] rd_word   = 32'b0;
  bit          spur      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Reference model: byte-offset arithmetic over the architectural access, not the RTL structure.
  task automatic predict(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gd, input int rd,
                         input logic [31:0] word, output exp_t e);
    bit          legal;
    bit          bad;
    int          size;
    int          off;
    logic [31:0] mask;
    logic [31:0] v;
    e = '{default: 0};
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    size  = 1 << f3[1:0];
    off   = int'(a[1:0]);
    bad   = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
    if (legal && (off % size) != 0) bad = 1'b1;
`endif
    if (bad) begin
      e.fault = 1'b1;
      e.stall = 1;
      e.rdata = 32'b0;
      last_rdata = 32'b0;
      return;
    end
    off       = off - (off % size);
    e.has_req = 1'b1;
    e.we      = !ld;
    e.maddr   = a & 32'hFFFF_FFFC;
    if (!ld) begin
      for (int i = 0; i < 4; i++) begin
        e.wstrb[i] = (i >= off) && (i < off + size);
        e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      end
      e.stall = 2 + gd;
      e.rdata = last_rdata;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      v = (word >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      e.stall = 3 + gd + rd;
      e.rdata = v;
      last_rdata = v;
    end
  endtask

  // Memory responder: grants after gnt_delay REQ cycles, returns data rv_delay cycles after grant.
  initial begin
    int req_cycles = 0;
    int rv_cnt = 0;
    bit pending_rd = 1'b0;
    mem.mem_gnt = 1'b0;
    mem.mem_rvalid = 1'b0;
    mem.mem_rdata = 32'b0;
    forever begin
      @(negedge clk);
      mem.mem_gnt = 1'b0;
      mem.mem_rvalid = 1'b0;
      mem.mem_rdata = $urandom;
      if (mem.mem_req) begin
        if (req_cycles >= gnt_delay) begin
          mem.mem_gnt = 1'b1;
          req_cycles = 0;
          pending_rd = !mem.mem_we;
          rv_cnt = 0;
        end else begin
          req_cycles++;
        end
        if (spur && $urandom_range(0, 3) == 0) mem.mem_rvalid = 1'b1;
      end else begin
        req_cycles = 0;
        if (pending_rd) begin
          if (rv_cnt >= rv_delay) begin
            mem.mem_rvalid = 1'b1;
            mem.mem_rdata = rd_word;
            pending_rd = 1'b0;
          end else begin
            rv_cnt++;
          end
        end else if (spur && $urandom_range(0, 3) == 0) begin
          mem.mem_rvalid = 1'b1;
        end
      end
    end
  end

  // Monitor: accumulates each access's stall/fault/request history and scores it at retirement.
  initial begin
    int          st_cnt = 0;
    int          flt_cnt = 0;
    bit          req_seen = 1'b0;
    bit          unstable = 1'b0;
    logic        c_we;
    logic [31:0] c_addr;
    logic [3:0]  c_wstrb;
    logic [31:0] c_wdata;
    exp_t        e;
    c_we = 1'b0; c_addr = 32'b0; c_wstrb = 4'b0; c_wdata = 32'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st_cnt = 0; flt_cnt = 0; req_seen = 1'b0; unstable = 1'b0;
      end else if (stall) begin
        st_cnt++;
        if (fault) flt_cnt++;
        if (mem.mem_req) begin
          if (!req_seen) begin
            c_we = mem.mem_we; c_addr = mem.mem_addr;
            c_wstrb = mem.mem_wstrb; c_wdata = mem.mem_wdata;
          end else if (c_we !== mem.mem_we || c_addr !== mem.mem_addr ||
                       c_wstrb !== mem.mem_wstrb || c_wdata !== mem.mem_wdata) begin
            unstable = 1'b1;
          end
          req_seen = 1'b1;
        end
      end else if (st_cnt > 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_retire: got retirement after %0d stall cycles, required none", st_cnt);
        end else begin
          e = exp_q.pop_front();
          chk("fault_cycles", 32'(flt_cnt), 32'(e.fault));
          chk("req_issued", 32'(req_seen), 32'(e.has_req));
          if (e.has_req) begin
            chk("mem_we", 32'(c_we), 32'(e.we));
            chk("mem_addr", c_addr, e.maddr);
            chk("mem_wstrb", 32'(c_wstrb), 32'(e.wstrb));
            if (e.we) chk("mem_wdata", c_wdata, e.wdata);
            chk("req_stable", 32'(unstable), 32'd0);
          end
          chk("stall_cycles", 32'(st_cnt), 32'(e.stall));
          chk("rdata", rdata, e.rdata);
        end
        st_cnt = 0; flt_cnt = 0; req_seen = 1'b0; unstable = 1'b0;
      end
    end
  end

  task automatic start(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int gd, input int rd, input logic [31:0] word);
    exp_t e;
    @(posedge clk);
    #1;
    gnt_delay = gd; rv_delay = rd; rd_word = word;
    load = ld; store = st; fun3 = f3; addr = a; wdata = wd;
    predict(ld, f3, a, wd, gd, rd, word, e);
    exp_q.push_back(e);
  endtask

  task automatic wait_retire();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 60);
    if (stall) begin
      n_checks++;
      $display("FAIL retire_timeout: stall still %0b after %0d cycles, required 0", stall, n);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "retire timeout");
    end
  endtask

  task automatic run(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int gd, input int rd, input logic [31:0] word);
    start(ld, st, f3, a, wd, gd, rd, word);
    wait_retire();
  endtask

  // Drops reset on a load parked in REQ (in_wait=0) or WAIT (in_wait=1); the access must vanish.
  task automatic reset_mid(input bit in_wait);
    bit saw_req = 1'b0;
    start(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'b0, in_wait ? 0 : 8, 5, 32'h5A5A_0F0F);
    void'(exp_q.pop_back());
    repeat (in_wait ? 3 : 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    load = 1'b0;
    store = 1'b0;
    last_rdata = 32'b0;
    #1;
    chk(in_wait ? "rst_wait_stall" : "rst_req_stall", 32'(stall), 32'd0);
    chk(in_wait ? "rst_wait_mem_req" : "rst_req_mem_req", 32'(mem.mem_req), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (mem.mem_req) saw_req = 1'b1;
    end
    chk("no_retry", 32'(saw_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b1; store = 1'b0; fun3 = 3'b0; addr = 32'b0; wdata = 32'b0;
    repeat (2) @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_mem_req", 32'(mem.mem_req), 32'd0);
    chk("reset_mem_we", 32'(mem.mem_we), 32'd0);
    chk("reset_mem_addr", mem.mem_addr, 32'd0);
    chk("reset_mem_wstrb", 32'(mem.mem_wstrb), 32'd0);
    chk("reset_mem_wdata", mem.mem_wdata, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    #1;
    rst_n = 1'b1;
    load = 1'b0;

    run(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 0, 0, 32'b0);
    run(1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'b0, 0, 0, 32'h1234_8056);
    run(1'b1, 1'b0, 3'b100, 32'h0000_0201, 32'b0, 0, 0, 32'h1234_8056);
    run(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 1, 0, 32'b0);
    run(1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'b0, 3, 0, 32'h8001_FFFF);
    run(1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'b0, 0, 0, 32'h1111_1111);
    run(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'b0, 0, 0, 32'hCAFE_F00D);
    run(1'b0, 1'b1, 3'b001, 32'h0000_0103, 32'h0000_1234, 0, 0, 32'b0);
    run(1'b1, 1'b1, 3'b101, 32'h0000_0042, 32'h0BAD_0BAD, 2, 2, 32'hF00D_9ABC);
    run(1'b0, 1'b1, 3'b100, 32'h0000_0020, 32'h0000_0077, 0, 0, 32'b0);

    reset_mid(1'b1);
    run(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'b0, 0, 0, 32'h0246_8ACE);
    reset_mid(1'b0);
    run(1'b1, 1'b0, 3'b101, 32'h0000_0086, 32'b0, 1, 1, 32'h9876_5432);

    spur = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int op;
      op = $urandom_range(0, 2);
      run(op != 1, op != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1 load = 1'b0; store = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    @(posedge clk);
    #1 load = 1'b0; store = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit
Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 load  input  1  current instruction is a load (from control decoder).
REQ-004 store  input  1  current instruction is a store (from control decoder).
REQ-005 fun3  input  3  instruction funct3; selects access size/signedness.
REQ-006 addr  input  32  effective byte address (ALU result).
REQ-007 wdata  input  32  store data (rs2).
REQ-008 stall  output  1  holds PC/regfile write while access is in flight.
REQ-009 rdata  output  32  aligned, extended load result; valid in DONE.
REQ-010 fault  output  1  one-cycle pulse: illegal fun3 (or misalignment, see REQ-030).
REQ-011 mem_req  output  1  registered memory request.
REQ-012 mem_we  output  1  1=write, 0=read; valid with mem_req.
REQ-013 mem_addr  output  32  word address, addr[31:2] followed by 2'b00.
REQ-014 mem_wstrb  output  4  byte lane enables; 4'b0000 on reads.
REQ-015 mem_wdata  output  32  lane-replicated store data.
REQ-016 mem_gnt  input  1  memory accepts request this cycle.
REQ-017 mem_rvalid  input  1  read data valid this cycle.
REQ-018 mem_rdata  input  32  raw word read data.
Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE; the unit SHALL have one access outstanding at most.
REQ-020 IDLE: if load|store, then stall=1 combinationally and next state=REQ, with mem_addr/we/wstrb/wdata and the size/sign/lane registered.
REQ-021 REQ: mem_req=1 and stall=1; on mem_gnt the FSM SHALL go to DONE for stores or WAIT for loads; without mem_gnt it SHALL hold with all request fields stable.
REQ-022 WAIT: stall=1, mem_req=0; on mem_rvalid the unit SHALL capture the extended data into the rdata register and go to DONE; mem_rvalid SHALL be ignored in all other states.
REQ-023 DONE: stall=0 for exactly one cycle (instruction retires), then the FSM SHALL return to IDLE; a new load|store is only accepted from IDLE.
REQ-024 Minimum stall: store 2 cycles, load 3 cycles (gnt and rvalid each on their first legal cycle).
REQ-025 Store lanes: sb wstrb=4'b0001<<addr[1:0], wdata byte replicated x4; sh wstrb=4'b0011<<{addr[1],1'b0}, halfword replicated x2; sw wstrb=4'b1111.
REQ-026 Load extract: lb/lbu byte lane addr[1:0], sign/zero extended; lh/lhu half lane addr[1], sign/zero extended; lw full word.
REQ-027 Legal fun3 values: loads 000,001,010,100,101; stores 000,001,010. Any other value SHALL pulse fault in IDLE, issue no request, and go straight to DONE with rdata=0.
REQ-028 If load and store are both asserted, load SHALL take priority and store SHALL be ignored.
REQ-029 rdata SHALL hold its last value outside DONE.
Reset
REQ-030 While rst_n=0: state=IDLE; stall, fault, mem_req and mem_we =0; mem_addr, mem_wdata and rdata =0; mem_wstrb=0. Reset mid-access SHALL drop mem_req immediately and abandon the access without retry.
REQ-031 Deassertion SHALL take effect on the first rising clk edge after rst_n rises.
Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN. When defined: half access with addr[0]=1, or word access with addr[1:0]!=0, SHALL pulse fault in IDLE, issue no request, and go to DONE.
REQ-033 When undefined: the offending low address bits SHALL be forced to zero (natural alignment) and the access SHALL proceed normally.
Structure
REQ-034 Package lsu_pkg SHALL hold the state encoding, the fun3 constants (LB..LHU, SB..SW) and the wstrb patterns.
REQ-035 Sub-module lsu_align SHALL be combinational store-lane replication/strobe generation plus load extraction/extension; the FSM stays in load_store_unit.
Verification
REQ-036 sb, addr=0x103, wdata=0x000000AB, gnt on first REQ cycle -> mem_addr=0x100, wstrb=4'b1000, mem_wdata=0xABABABAB, stall 2 cycles.
REQ-037 lb, addr=0x201, mem_rdata=0x12348056, rvalid 1 cycle after gnt -> rdata=0xFFFFFF80 in DONE; lbu same -> 0x00000080.
REQ-038 lh, addr=0x302, mem_rdata=0x8001FFFF -> rdata=0xFFFF8001; gnt delayed 3 cycles -> request fields held stable, stall 6 cycles.
REQ-039 load with fun3=3'b011 -> fault pulse, mem_req never asserted, stall 1 cycle; lw at addr=0x2 -> fault with LSU_MISALIGN_TRAP_EN, else read at 0x0.
REQ-040 rst_n low while in WAIT -> stall and mem_req 0 immediately; a later rvalid is ignored and the next load completes normally.
